// File: rtl/imm_decode_stage_pkg.sv
// Shared types for the decode-side immediate stage: opcodes, ImmSrc encoding, FSM states,
// the registered entry layout and the opcode classifier.
package imm_decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_CSR = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  // pc is kept beside this struct because its width is a parameter of the stage
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    imm_src_e    imm_src;
    logic        has_imm;
    logic        illegal;
  } dec_entry_t;

  typedef struct packed {
    imm_src_e imm_src;
    logic     has_imm;
    logic     illegal;
  } opc_class_t;

  function automatic opc_class_t classify(input logic [31:0] instr, input logic csr_imm_en);
    opc_class_t c;
    c.imm_src = IMM_I;
    c.has_imm = 1'b1;
    c.illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      c.has_imm = 1'b0;
      c.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: c.imm_src = IMM_I;
        OPC_STORE:            c.imm_src = IMM_S;
        OPC_BRANCH:           c.imm_src = IMM_B;
        OPC_LUI, OPC_AUIPC:   c.imm_src = IMM_U;
        OPC_JAL:              c.imm_src = IMM_J;
        OPC_SYSTEM:           c.imm_src = (csr_imm_en && instr[14]) ? IMM_CSR : IMM_I;
        OPC_OP:               c.has_imm = 1'b0;
        default: begin
          c.has_imm = 1'b0;
          c.illegal = 1'b1;
        end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/imm_decode_stage_immgen.sv
// ImmediateGenerator: builds the 32-bit immediate from instr[31:7] for the selected ImmSrc.
// Purely combinational; bit d[k] below is instr[k+7].
module imm_decode_stage_immgen
  import imm_decode_stage_pkg::*;
(
  input  logic [24:0] i_instr,
  input  imm_src_e    i_imm_src,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = 32'd0;
    case (i_imm_src)
      IMM_I:   o_imm = {{20{i_instr[24]}}, i_instr[24:13]};
      IMM_S:   o_imm = {{20{i_instr[24]}}, i_instr[24:18], i_instr[4:0]};
      IMM_B:   o_imm = {{20{i_instr[24]}}, i_instr[0], i_instr[23:18], i_instr[4:1], 1'b0};
      IMM_U:   o_imm = {i_instr[24:5], 12'd0};
      IMM_J:   o_imm = {{12{i_instr[24]}}, i_instr[12:5], i_instr[13], i_instr[23:14], 1'b0};
      IMM_CSR: o_imm = {27'd0, i_instr[12:8]};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: classifies instr_i, generates its immediate and registers the result into a
// 2-entry skid buffer (1-cycle latency, 1/cycle throughput, ready_o registered).
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter bit CSR_IMM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic [31:0]     imm_o,
  output logic [2:0]      imm_src_o,
  output logic            has_imm_o,
  output logic            illegal_o
);

  opc_class_t   w_class;
  logic [31:0]  w_imm;
  dec_entry_t   w_entry;
  logic         w_accept;

  stage_state_e    r_state;
  logic            r_valid;
  logic            r_ready;
  dec_entry_t      r_out;
  dec_entry_t      r_skid;
  logic [PC_W-1:0] r_out_pc;
  logic [PC_W-1:0] r_skid_pc;

  assign w_class = classify(instr_i, CSR_IMM_EN);

  imm_decode_stage_immgen u_immgen (
    .i_instr   (instr_i[31:7]),
    .i_imm_src (w_class.imm_src),
    .o_imm     (w_imm)
  );

  always_comb begin
    w_entry.instr   = instr_i;
    w_entry.imm     = w_class.has_imm ? w_imm : 32'd0;
    w_entry.imm_src = w_class.imm_src;
    w_entry.has_imm = w_class.has_imm;
    w_entry.illegal = w_class.illegal;
  end

  assign w_accept = valid_i && r_ready;

  // flush wins over every transition, including a same-cycle output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_valid   <= 1'b0;
      r_ready   <= 1'b1;
      r_out     <= '0;
      r_skid    <= '0;
      r_out_pc  <= '0;
      r_skid_pc <= '0;
    end else if (flush_i) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out    <= w_entry;
            r_out_pc <= pc_i;
            r_state  <= ST_FULL;
            r_valid  <= 1'b1;
            r_ready  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept && ready_i) begin
            r_out    <= w_entry;
            r_out_pc <= pc_i;
          end else if (w_accept) begin
            r_skid    <= w_entry;
            r_skid_pc <= pc_i;
            r_state   <= ST_SKID;
            r_ready   <= 1'b0;
          end else if (ready_i) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end
        end
        ST_SKID: begin
          if (ready_i) begin
            r_out    <= r_skid;
            r_out_pc <= r_skid_pc;
            r_state  <= ST_FULL;
            r_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign valid_o   = r_valid;
  assign ready_o   = r_ready;
  assign instr_o   = r_out.instr;
  assign pc_o      = r_out_pc;
  assign imm_o     = r_out.imm;
  assign imm_src_o = r_out.imm_src;
  assign has_imm_o = r_out.has_imm;
  assign illegal_o = r_out.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors, skid/backpressure, flush and async reset.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] imm_o;
  logic [2:0]  imm_src_o;
  logic        has_imm_o;
  logic        illegal_o;

  logic        d0_ready_o;
  logic        d0_valid_o;
  logic [31:0] d0_instr_o;
  logic [31:0] d0_pc_o;
  logic [31:0] d0_imm_o;
  logic [2:0]  d0_imm_src_o;
  logic        d0_has_imm_o;
  logic        d0_illegal_o;

  int errors;
  int checks;

  imm_decode_stage #(.PC_W(32), .CSR_IMM_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .imm_o(imm_o), .imm_src_o(imm_src_o),
    .has_imm_o(has_imm_o), .illegal_o(illegal_o)
  );

  imm_decode_stage #(.PC_W(32), .CSR_IMM_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(d0_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .valid_o(d0_valid_o), .ready_i(ready_i),
    .instr_o(d0_instr_o), .pc_o(d0_pc_o), .imm_o(d0_imm_o), .imm_src_o(d0_imm_src_o),
    .has_imm_o(d0_has_imm_o), .illegal_o(d0_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    instr_i = 32'd0; pc_i = 32'd0;
    #12;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: valid_o=%b ready_o=%b expected 0/1", valid_o, ready_o);
    end
    checks++;
    if (imm_o !== 32'd0 || pc_o !== 32'd0 || instr_o !== 32'd0 || imm_src_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: imm=%h pc=%h instr=%h src=%b expected zeros", imm_o, pc_o, instr_o, imm_src_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] v_instr [9];
    logic [31:0] v_imm   [9];
    logic [2:0]  v_src   [9];
    logic        v_has   [9];
    logic        v_ill   [9];
    v_instr[0] = 32'hFFF00093; v_imm[0] = 32'hFFFFFFFF; v_src[0] = 3'b000; v_has[0] = 1; v_ill[0] = 0;
    v_instr[1] = 32'hFE000EE3; v_imm[1] = 32'hFFFFFFFC; v_src[1] = 3'b010; v_has[1] = 1; v_ill[1] = 0;
    v_instr[2] = 32'h12345037; v_imm[2] = 32'h12345000; v_src[2] = 3'b011; v_has[2] = 1; v_ill[2] = 0;
    v_instr[3] = 32'h0052D073; v_imm[3] = 32'h00000005; v_src[3] = 3'b101; v_has[3] = 1; v_ill[3] = 0;
    v_instr[4] = 32'h002081B3; v_imm[4] = 32'h00000000; v_src[4] = 3'b000; v_has[4] = 0; v_ill[4] = 0;
    v_instr[5] = 32'h0000007F; v_imm[5] = 32'h00000000; v_src[5] = 3'b000; v_has[5] = 0; v_ill[5] = 1;
    v_instr[6] = 32'h008000EF; v_imm[6] = 32'h00000008; v_src[6] = 3'b100; v_has[6] = 1; v_ill[6] = 0;
    v_instr[7] = 32'h0020A423; v_imm[7] = 32'h00000008; v_src[7] = 3'b001; v_has[7] = 1; v_ill[7] = 0;
    v_instr[8] = 32'h00000090; v_imm[8] = 32'h00000000; v_src[8] = 3'b000; v_has[8] = 0; v_ill[8] = 1;
    ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      valid_i = 1'b1; instr_i = v_instr[k]; pc_i = 32'h1000 + 32'(k * 4);
      tick();
      valid_i = 1'b0;
      checks++;
      if (valid_o !== 1'b1 || pc_o !== 32'h1000 + 32'(k * 4) || instr_o !== v_instr[k]) begin
        errors++;
        $display("FAIL decode_hold[%0d]: valid=%b pc=%h instr=%h expected 1/%h/%h",
                 k, valid_o, pc_o, instr_o, 32'h1000 + 32'(k * 4), v_instr[k]);
      end
      checks++;
      if (imm_o !== v_imm[k] || imm_src_o !== v_src[k] || has_imm_o !== v_has[k] || illegal_o !== v_ill[k]) begin
        errors++;
        $display("FAIL decode_imm[%0d]: imm=%h src=%b has=%b ill=%b expected %h/%b/%b/%b",
                 k, imm_o, imm_src_o, has_imm_o, illegal_o, v_imm[k], v_src[k], v_has[k], v_ill[k]);
      end
      if (k == 3) begin
        checks++;
        if (d0_imm_src_o !== 3'b000 || d0_imm_o !== 32'h00000005) begin
          errors++;
          $display("FAIL csr_imm_off: src=%b imm=%h expected 000/00000005", d0_imm_src_o, d0_imm_o);
        end
      end
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL decode_drain: valid=%b ready=%b expected 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [31:0] got [$];
    idx = 0;
    instr_i = 32'hFFF00093;
    for (int c = 0; c < 12; c++) begin
      ready_i = (c >= 3);
      valid_i = (idx < 4);
      pc_i    = 32'(idx * 4);
      if (c == 1 || c == 2) begin
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
          errors++;
          $display("FAIL b2b_hold[c%0d]: valid=%b pc=%h expected 1/0", c, valid_o, pc_o);
        end
      end
      if (c == 2) begin
        checks++;
        if (ready_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b_skid_ready: ready_o=%b expected 0", ready_o);
        end
      end
      if (valid_o && ready_i) got.push_back(pc_o);
      if (valid_i && ready_o) idx++;
      tick();
    end
    valid_i = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs expected 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== 32'(k * 4)) begin
          errors++;
          $display("FAIL b2b_order[%0d]: pc=%h expected %h", k, got[k], 32'(k * 4));
        end
      end
    end
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: valid=%b ready=%b expected 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h12345037; pc_i = 32'h100;
    tick();
    pc_i = 32'h104;
    tick();
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_skid: ready=%b valid=%b expected 0/1", ready_o, valid_o);
    end
    flush_i = 1'b1; pc_i = 32'h108; ready_i = 1'b1;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_skid: valid=%b ready=%b expected 0/1", valid_o, ready_o);
    end
    // flush in FULL while the stage is ready: offered instr must be dropped
    valid_i = 1'b1; pc_i = 32'h200;
    tick();
    flush_i = 1'b1; pc_i = 32'h204;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_full[c%0d]: valid=%b pc=%h expected valid 0", c, valid_o, pc_o);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h002081B3; pc_i = 32'h300;
    tick();
    pc_i = 32'h304;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_immediate: valid=%b ready=%b expected 0/1", valid_o, ready_o);
    end
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ready_i = 1'b1; valid_i = 1'b1; instr_i = 32'h0052D073; pc_i = 32'h400;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h400 || imm_o !== 32'h5 || imm_src_o !== 3'b101) begin
      errors++;
      $display("FAIL arst_first: valid=%b pc=%h imm=%h src=%b expected 1/400/5/101",
               valid_o, pc_o, imm_o, imm_src_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_drain: valid=%b expected 0", valid_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
